uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of payload bits per frame.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel payload word.
REQ-005 SHALL have port Data_Valid  input  1  request to send P_DATA.
REQ-006 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port Prescale  input  6  clock cycles per bit, matching the receiver oversampling ratio.
REQ-009 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-010 SHALL have port Busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept a request when Data_Valid=1 in IDLE, or in the last STOP cycle; otherwise Data_Valid SHALL be ignored.
REQ-013 On accept SHALL latch P_DATA, PAR_EN, PAR_TYP and Prescale; input changes mid-frame SHALL have no effect.
REQ-014 SHALL enter START on the cycle after accept, with TX_OUT=0 and Busy=1 on that cycle (latency 1 cycle).
REQ-015 SHALL hold each bit for exactly latched-Prescale cycles, counted by a 6-bit edge counter that resets at every bit boundary.
REQ-016 A latched Prescale of 0 SHALL be treated as 1.
REQ-017 SHALL send DATA bits LSB first, DATA_WIDTH bits, using a bit counter cleared on entering DATA.
REQ-018 After the last data bit SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-019 Parity bit SHALL be XOR of the latched payload for even, inverted XOR for odd.
REQ-020 STOP SHALL drive TX_OUT=1 for one bit time.
REQ-021 At the end of STOP, with no accept, SHALL return to IDLE; Busy=0 from the next cycle.
REQ-022 On accept in the last STOP cycle SHALL go directly to START with no idle gap, and Busy SHALL stay 1.
REQ-023 Frame length SHALL be (2 + DATA_WIDTH + PAR_EN) x Prescale cycles.
REQ-024 TX_OUT and Busy SHALL be registered outputs.

Reset
REQ-025 RST=1 at a clock edge SHALL force IDLE, TX_OUT=1, Busy=0, and clear all counters and latches, including mid-frame.
REQ-026 Data_Valid asserted during reset SHALL be ignored; the first accept SHALL be possible on the first cycle after RST deasserts.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined SHALL compile in the PARITY state and parity generation as specified.
REQ-028 Macro UART_TX_PARITY_EN undefined SHALL remove the PARITY state; PAR_EN and PAR_TYP stay as ports but are ignored; every frame is 2+DATA_WIDTH bits.

Verification
REQ-029 Scenario: P_DATA=0xA5, PAR_EN=0, Prescale=8 -> TX_OUT 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; Busy high 80 cycles.
REQ-030 Scenario: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=16 -> parity bit 0 after data; frame 176 cycles.
REQ-031 Scenario: P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; P_DATA=0x00 odd -> parity bit 1.
REQ-032 Scenario: Data_Valid held high with 0x55 then 0x0F, Prescale=8 -> second start bit immediately follows the first stop bit; Busy never drops.
REQ-033 Scenario: change P_DATA to 0xFF and pulse Data_Valid mid-frame of 0x3C -> 0x3C sent unchanged, the pulse ignored.
REQ-034 Scenario: RST=1 during DATA of a Prescale=32 frame -> next cycle TX_OUT=1, Busy=0; a new request then sends a clean full frame.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core
//   Serial UART transmitter. A parallel payload word is framed as a start
//   bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit,
//   and a stop bit (1). Each bit is held for Prescale clock cycles.
//   A Prescale of 0 is treated as 1.
//
//   Configuration macro: UART_TX_PARITY_EN
//     defined   - the PARITY state and parity generation are built in.
//     undefined - there is no PARITY state. PAR_EN and PAR_TYP are ignored,
//                 and every frame has 2 + DATA_WIDTH bits.
//
// Ports
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset
//   P_DATA      payload word, latched when a request is accepted
//   Data_Valid  send request; accepted in IDLE or in the last STOP cycle
//   PAR_EN      1 = append a parity bit (latched on accept)
//   PAR_TYP     0 = even parity, 1 = odd parity (latched on accept)
//   Prescale    clock cycles per bit (latched on accept)
//   TX_OUT      registered serial line, idle high
//   Busy        registered, high while a frame is in progress

module uart_tx_core #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_e;
`endif

  state_e                state_q;
  logic [5:0]            cnt_q;
  logic [BW-1:0]         bitIdx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [5:0]            presc_q;
  logic                  txOut_q;
  logic                  busy_q;

`ifdef UART_TX_PARITY_EN
  logic                  parEn_q;
  logic                  parBit_q;
  logic                  parBit_d;

  // The parity bit is resolved at accept time, so the odd/even selection
  // only has to be stored as its effect on this single bit.
  assign parBit_d = (^P_DATA) ^ PAR_TYP;
`else
  logic                  unusedParityInputs;

  assign unusedParityInputs = PAR_EN ^ PAR_TYP;
`endif

  logic [5:0] presc_d;
  logic       lastCycle;
  logic       accept;

  // A zero prescale would otherwise never terminate a bit, so it is
  // promoted to a one-cycle bit before being latched.
  assign presc_d   = (Prescale == 6'd0) ? 6'd1 : Prescale;
  assign lastCycle = (cnt_q == (presc_q - 6'd1));

  // Requests are taken when idle, or in the last stop cycle so that a
  // back-to-back frame starts with no idle gap between frames.
  assign accept = Data_Valid &&
                  ((state_q == IDLE) || ((state_q == STOP) && lastCycle));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      presc_q  <= 6'd0;
      txOut_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parEn_q  <= 1'b0;
      parBit_q <= 1'b0;
`endif
    end else if (accept) begin
      shift_q  <= P_DATA;
      presc_q  <= presc_d;
`ifdef UART_TX_PARITY_EN
      parEn_q  <= PAR_EN;
      parBit_q <= parBit_d;
`endif
      state_q  <= START;
      cnt_q    <= 6'd0;
      bitIdx_q <= '0;
      txOut_q  <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txOut_q <= 1'b1;
          busy_q  <= 1'b0;
        end

        START: begin
          if (lastCycle) begin
            state_q  <= DATA;
            cnt_q    <= 6'd0;
            bitIdx_q <= '0;
            txOut_q  <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

        // The payload shifts right so the next bit to send is always bit 0;
        // bitIdx_q only tracks how many bits have gone out.
        DATA: begin
          if (lastCycle) begin
            cnt_q <= 6'd0;
            if (bitIdx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              if (parEn_q) begin
                state_q <= PARITY;
                txOut_q <= parBit_q;
              end else begin
                state_q <= STOP;
                txOut_q <= 1'b1;
              end
`else
              state_q <= STOP;
              txOut_q <= 1'b1;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 1'b1;
              txOut_q  <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (lastCycle) begin
            state_q <= STOP;
            cnt_q   <= 6'd0;
            txOut_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
`endif

        STOP: begin
          if (lastCycle) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            txOut_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= 6'd0;
          txOut_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = txOut_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core
//   Directed testbench for uart_tx_core. Each request pushes the expected
//   line levels of its frame into a scoreboard queue. The queue is then
//   walked cycle by cycle against TX_OUT and Busy. Parity bits are expected
//   only when the design is built with UART_TX_PARITY_EN.

module tb_uart_tx_core;

  localparam int DW = 8;

`ifdef UART_TX_PARITY_EN
  localparam bit PARITY_BUILT = 1'b1;
`else
  localparam bit PARITY_BUILT = 1'b0;
`endif

  typedef struct {
    logic level;
    int   hold;
    bit   lastOfFrame;
  } bitExp_t;

  bitExp_t expQ[$];
  int checks = 0;
  int errors = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pData = '0;
  logic          dataValid = 1'b0;
  logic          parEnIn = 1'b0;
  logic          parTypIn = 1'b0;
  logic [5:0]    prescale = 6'd8;
  logic          txOut;
  logic          busy;

  uart_tx_core #(.DATA_WIDTH(DW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (pData),
    .Data_Valid (dataValid),
    .PAR_EN     (parEnIn),
    .PAR_TYP    (parTypIn),
    .Prescale   (prescale),
    .TX_OUT     (txOut),
    .Busy       (busy)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Drives one request and records the frame it should produce.
  // With chain set, the inputs are only updated, because Data_Valid is
  // already held high for a back-to-back accept in the last stop cycle.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic parEn,
                               input logic parTyp, input logic [5:0] presc,
                               input bit keepValid, input bit chain);
    int hold;
    hold = (presc == 6'd0) ? 1 : int'(presc);
    if (!chain) @(negedge clk);
    pData     = data;
    parEnIn   = parEn;
    parTypIn  = parTyp;
    prescale  = presc;
    dataValid = 1'b1;
    expQ.push_back('{1'b0, hold, 1'b0});
    for (int i = 0; i < DW; i++) expQ.push_back('{data[i], hold, 1'b0});
    if (parEn && PARITY_BUILT) expQ.push_back('{(^data) ^ parTyp, hold, 1'b0});
    expQ.push_back('{1'b1, hold, 1'b1});
    if (!chain) begin
      @(posedge clk);
      #1;
      if (!keepValid) dataValid = 1'b0;
    end
  endtask

  // Walks the scoreboard one cycle at a time, starting #1 after the accept
  // edge. disturbAt >= 0 pulses Data_Valid with altered inputs at that cycle.
  // maxCycles < total stops early and discards the remaining expectations.
  task automatic checkOutput(input string tag, input int disturbAt, input int maxCycles);
    int cyc;
    int busyCycles;
    int expCycles;
    bitExp_t e;
    cyc = 0;
    busyCycles = 0;
    expCycles = 0;
    while (expQ.size() > 0 && cyc < maxCycles) begin
      e = expQ.pop_front();
      for (int j = 0; j < e.hold && cyc < maxCycles; j++) begin
        if (disturbAt >= 0 && cyc == disturbAt) begin
          pData     = '1;
          prescale  = 6'd2;
          parEnIn   = ~parEnIn;
          dataValid = 1'b1;
        end else if (disturbAt >= 0 && cyc == disturbAt + 1) begin
          dataValid = 1'b0;
        end
        checks++;
        assert (txOut === e.level) else begin
          errors++;
          $error("[TB] FAIL %s txOut cycle %0d: observed %b expected %b", tag, cyc, txOut, e.level);
        end
        checks++;
        assert (busy === 1'b1) else begin
          errors++;
          $error("[TB] FAIL %s busy cycle %0d: observed %b expected 1", tag, cyc, busy);
        end
        if (busy === 1'b1) busyCycles++;
        expCycles++;
        cyc++;
        @(posedge clk);
        #1;
      end
      if (e.lastOfFrame && expQ.size() > 0) dataValid = 1'b0;
    end
    if (cyc < maxCycles) begin
      checks++;
      assert (busyCycles == expCycles) else begin
        errors++;
        $error("[TB] FAIL %s busyLength: observed %0d expected %0d", tag, busyCycles, expCycles);
      end
      checks++;
      assert (busy === 1'b0) else begin
        errors++;
        $error("[TB] FAIL %s busyAfterFrame: observed %b expected 0", tag, busy);
      end
      checks++;
      assert (txOut === 1'b1) else begin
        errors++;
        $error("[TB] FAIL %s lineAfterFrame: observed %b expected 1", tag, txOut);
      end
    end else begin
      expQ.delete();
    end
  endtask

  // Directed sequence: reset, plain and parity frames, chaining,
  // mid-frame disturbance, zero prescale, and reset in mid-frame
  initial begin
    $display("[TB] start, parity built = %0d", PARITY_BUILT);

    dataValid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (txOut === 1'b1) else begin
      errors++;
      $error("[TB] FAIL reset txOut: observed %b expected 1", txOut);
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("[TB] FAIL reset busy: observed %b expected 0", busy);
    end

    rst = 1'b0;
    dataValid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    assert (txOut === 1'b1 && busy === 1'b0) else begin
      errors++;
      $error("[TB] FAIL idleAfterReset: observed tx=%b busy=%b expected tx=1 busy=0", txOut, busy);
    end

    applyStimulus(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
    checkOutput("a5NoParity", -10, 100000);

    applyStimulus(8'hA5, 1'b1, 1'b0, 6'd16, 1'b0, 1'b0);
    checkOutput("a5EvenParity", -10, 100000);

    applyStimulus(8'h01, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0);
    checkOutput("01OddParity", -10, 100000);

    applyStimulus(8'h00, 1'b1, 1'b1, 6'd4, 1'b0, 1'b0);
    checkOutput("00OddParity", -10, 100000);

    applyStimulus(8'h55, 1'b0, 1'b0, 6'd8, 1'b1, 1'b0);
    applyStimulus(8'h0F, 1'b0, 1'b0, 6'd8, 1'b1, 1'b1);
    checkOutput("backToBack", -10, 100000);

    applyStimulus(8'h3C, 1'b0, 1'b0, 6'd4, 1'b0, 1'b0);
    checkOutput("midFrameChange", 10, 100000);

    applyStimulus(8'h5A, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    checkOutput("prescaleZero", -10, 100000);

    applyStimulus(8'h96, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0);
    checkOutput("beforeReset", -10, 96);
    rst = 1'b1;
    dataValid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    assert (txOut === 1'b1) else begin
      errors++;
      $error("[TB] FAIL midFrameReset txOut: observed %b expected 1", txOut);
    end
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("[TB] FAIL midFrameReset busy: observed %b expected 0", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (txOut === 1'b1 && busy === 1'b0) else begin
      errors++;
      $error("[TB] FAIL validDuringReset: observed tx=%b busy=%b expected tx=1 busy=0", txOut, busy);
    end
    rst = 1'b0;
    applyStimulus(8'hC3, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0);
    checkOutput("afterReset", -10, 100000);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (txOut === 1'b1 && busy === 1'b0) else begin
      errors++;
      $error("[TB] FAIL finalIdle: observed tx=%b busy=%b expected tx=1 busy=0", txOut, busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
